// File: rtl/alu_pkg.sv
// Shared types for the two-port ALU arbiter: op codes, one-hot ALU select, FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAdd = 4'd0,
    OpSub = 4'd1,
    OpAnd = 4'd2,
    OpOr  = 4'd3,
    OpXor = 4'd4,
    OpSll = 4'd5,
    OpSra = 4'd6,
    OpSrl = 4'd7
  } alu_op_t;

  typedef struct packed {
    logic op_add;
    logic op_sub;
    logic op_and;
    logic op_or;
    logic op_xor;
    logic op_sll;
    logic op_sra;
    logic op_srl;
  } alu_onehot_t;

  typedef struct packed {
    alu_onehot_t sel;
    logic        is_shift;
    logic        illegal;
  } alu_decode_t;

  typedef enum logic [0:0] {
    StIdle,
    StHold
  } arb_state_t;

  // Codes 8..15 decode to an all-zero select so the ALU returns 0.
  function automatic alu_decode_t decode_op(alu_op_t op);
    alu_decode_t d;
    d = '0;
    case (op)
      OpAdd:   d.sel.op_add = 1'b1;
      OpSub:   d.sel.op_sub = 1'b1;
      OpAnd:   d.sel.op_and = 1'b1;
      OpOr:    d.sel.op_or  = 1'b1;
      OpXor:   d.sel.op_xor = 1'b1;
      OpSll:   begin d.sel.op_sll = 1'b1; d.is_shift = 1'b1; end
      OpSra:   begin d.sel.op_sra = 1'b1; d.is_shift = 1'b1; end
      OpSrl:   begin d.sel.op_srl = 1'b1; d.is_shift = 1'b1; end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on contention the port that did not win last time is granted.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       enable,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters with a registered,
// per-port result held until the owner consumes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned X_LENGTH    = 32,
  parameter int unsigned OP_WIDTH    = 4,
  parameter int unsigned SHAMT_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [OP_WIDTH-1:0] req0_op,
  input  logic [X_LENGTH-1:0] req0_operand_1,
  input  logic [X_LENGTH-1:0] req0_operand_2,
  output logic                resp0_valid,
  input  logic                resp0_ready,
  output logic [X_LENGTH-1:0] resp0_result,
  output logic                resp0_error,

  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [OP_WIDTH-1:0] req1_op,
  input  logic [X_LENGTH-1:0] req1_operand_1,
  input  logic [X_LENGTH-1:0] req1_operand_2,
  output logic                resp1_valid,
  input  logic                resp1_ready,
  output logic [X_LENGTH-1:0] resp1_result,
  output logic                resp1_error,

  output logic                alu_operation_add,
  output logic                alu_operation_subtract,
  output logic                alu_operation_and,
  output logic                alu_operation_or,
  output logic                alu_operation_xor,
  output logic                alu_operation_shift_left_logical,
  output logic                alu_operation_shift_right_arithmetic,
  output logic                alu_operation_shift_right_logical,
  output logic [X_LENGTH-1:0] alu_operand_1,
  output logic [X_LENGTH-1:0] alu_operand_2,
  input  logic [X_LENGTH-1:0] alu_result
);

  arb_state_t          state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic [1:0]          resp_valid_q, resp_valid_d;
  logic [X_LENGTH-1:0] result_q [2];
  logic [X_LENGTH-1:0] result_d [2];
  logic [1:0]          error_q, error_d;

  logic [1:0]          req_valid;
  logic [1:0]          resp_ready;
  logic [1:0]          grant;
  logic                handshake;
  logic                can_accept;
  logic                accept;
  logic                grant_idx;
  logic [OP_WIDTH-1:0] sel_op;
  logic [X_LENGTH-1:0] sel_a;
  logic [X_LENGTH-1:0] sel_b;
  alu_decode_t         dec;
  alu_onehot_t         alu_sel;

  assign req_valid  = {req1_valid, req0_valid};
  assign resp_ready = {resp1_ready, resp0_ready};

  assign handshake  = (state_q == StHold) & resp_valid_q[owner_q] & resp_ready[owner_q];
  assign can_accept = (state_q == StIdle) | handshake;

  rr_arbiter2 u_rr_arbiter2 (
    .valid      (req_valid),
    .enable     (can_accept & ~rst),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // grant is already qualified by valid, so any grant bit is an accept.
  assign accept    = |grant;
  assign grant_idx = grant[1];

  assign sel_op = grant_idx ? req1_op        : req0_op;
  assign sel_a  = grant_idx ? req1_operand_1 : req0_operand_1;
  assign sel_b  = grant_idx ? req1_operand_2 : req0_operand_2;
  assign dec    = decode_op(alu_op_t'(sel_op));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      resp_valid_q <= 2'b00;
      result_q[0]  <= '0;
      result_q[1]  <= '0;
      error_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      resp_valid_q <= resp_valid_d;
      result_q[0]  <= result_d[0];
      result_q[1]  <= result_d[1];
      error_q      <= error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    resp_valid_d = resp_valid_q;
    result_d[0]  = result_q[0];
    result_d[1]  = result_q[1];
    error_d      = error_q;
    if (handshake) begin
      resp_valid_d[owner_q] = 1'b0;
    end
    if (accept) begin
      resp_valid_d[grant_idx] = 1'b1;
      result_d[grant_idx]     = dec.illegal ? '0 : alu_result;
      error_d[grant_idx]      = dec.illegal;
      owner_d                 = grant_idx;
      last_grant_d            = grant_idx;
      state_d                 = StHold;
    end else if (handshake) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    alu_sel       = '0;
    alu_operand_1 = '0;
    alu_operand_2 = '0;
    if (accept) begin
      alu_sel       = dec.sel;
      alu_operand_1 = sel_a;
      alu_operand_2 = dec.is_shift ? {{(X_LENGTH-SHAMT_WIDTH){1'b0}}, sel_b[SHAMT_WIDTH-1:0]}
                                   : sel_b;
    end
  end

  assign alu_operation_add                    = alu_sel.op_add;
  assign alu_operation_subtract               = alu_sel.op_sub;
  assign alu_operation_and                    = alu_sel.op_and;
  assign alu_operation_or                     = alu_sel.op_or;
  assign alu_operation_xor                    = alu_sel.op_xor;
  assign alu_operation_shift_left_logical     = alu_sel.op_sll;
  assign alu_operation_shift_right_arithmetic = alu_sel.op_sra;
  assign alu_operation_shift_right_logical    = alu_sel.op_srl;

  assign req0_ready   = grant[0];
  assign req1_ready   = grant[1];
  assign resp0_valid  = resp_valid_q[0];
  assign resp1_valid  = resp_valid_q[1];
  assign resp0_result = result_q[0];
  assign resp1_result = result_q[1];
  assign resp0_error  = error_q[0];
  assign resp1_error  = error_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a transaction-level model checked every cycle plus
// hand-computed expectations for each scenario.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_error;
  logic        req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_error;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_operand_1, req0_operand_2, req1_operand_1, req1_operand_2;
  logic [31:0] resp0_result, resp1_result;
  logic        op_add, op_sub, op_and, op_or, op_xor, op_sll, op_sra, op_srl;
  logic [31:0] alu_operand_1, alu_operand_2, alu_result;
  logic [7:0]  bus;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk                                  (clk),
    .rst                                  (rst),
    .req0_valid                           (req0_valid),
    .req0_ready                           (req0_ready),
    .req0_op                              (req0_op),
    .req0_operand_1                       (req0_operand_1),
    .req0_operand_2                       (req0_operand_2),
    .resp0_valid                          (resp0_valid),
    .resp0_ready                          (resp0_ready),
    .resp0_result                         (resp0_result),
    .resp0_error                          (resp0_error),
    .req1_valid                           (req1_valid),
    .req1_ready                           (req1_ready),
    .req1_op                              (req1_op),
    .req1_operand_1                       (req1_operand_1),
    .req1_operand_2                       (req1_operand_2),
    .resp1_valid                          (resp1_valid),
    .resp1_ready                          (resp1_ready),
    .resp1_result                         (resp1_result),
    .resp1_error                          (resp1_error),
    .alu_operation_add                    (op_add),
    .alu_operation_subtract               (op_sub),
    .alu_operation_and                    (op_and),
    .alu_operation_or                     (op_or),
    .alu_operation_xor                    (op_xor),
    .alu_operation_shift_left_logical     (op_sll),
    .alu_operation_shift_right_arithmetic (op_sra),
    .alu_operation_shift_right_logical    (op_srl),
    .alu_operand_1                        (alu_operand_1),
    .alu_operand_2                        (alu_operand_2),
    .alu_result                           (alu_result)
  );

  // Bit i of bus corresponds to op code i.
  assign bus = {op_srl, op_sra, op_sll, op_xor, op_or, op_and, op_sub, op_add};

  // Environment ALU driven by the one-hot select.
  always_comb begin
    alu_result = 32'd0;
    if (op_add) alu_result = alu_operand_1 + alu_operand_2;
    if (op_sub) alu_result = alu_operand_1 - alu_operand_2;
    if (op_and) alu_result = alu_operand_1 & alu_operand_2;
    if (op_or)  alu_result = alu_operand_1 | alu_operand_2;
    if (op_xor) alu_result = alu_operand_1 ^ alu_operand_2;
    if (op_sll) alu_result = alu_operand_1 << alu_operand_2;
    if (op_sra) alu_result = $unsigned($signed(alu_operand_1) >>> alu_operand_2);
    if (op_srl) alu_result = alu_operand_1 >> alu_operand_2;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return $unsigned($signed(a) >>> b[4:0]);
      4'd7:    return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  // Transaction model: which port has an unconsumed result, and what it must be.
  logic        m_pend [2] = '{1'b0, 1'b0};
  logic [31:0] m_res  [2] = '{32'd0, 32'd0};
  logic        m_err  [2] = '{1'b0, 1'b0};
  int          m_last     = 1;
  int          e_g        = -1;
  logic        e_hs       = 1'b0;
  int          e_hs_port  = 0;
  logic [3:0]  e_op;
  logic [31:0] e_a, e_b;

  always @(negedge clk) begin
    logic can;
    logic [31:0] exp_b;
    e_hs = 1'b0;
    if (m_pend[0] && resp0_ready) begin e_hs = 1'b1; e_hs_port = 0; end
    if (m_pend[1] && resp1_ready) begin e_hs = 1'b1; e_hs_port = 1; end
    can = !(m_pend[0] || m_pend[1]) || e_hs;
    e_g = -1;
    if (can && !rst) begin
      if (req0_valid && req1_valid) e_g = (m_last == 1) ? 0 : 1;
      else if (req0_valid)          e_g = 0;
      else if (req1_valid)          e_g = 1;
    end
    e_op = (e_g == 1) ? req1_op : req0_op;
    e_a  = (e_g == 1) ? req1_operand_1 : req0_operand_1;
    e_b  = (e_g == 1) ? req1_operand_2 : req0_operand_2;
    chk("m_req0_ready", {31'd0, req0_ready}, {31'd0, e_g == 0});
    chk("m_req1_ready", {31'd0, req1_ready}, {31'd0, e_g == 1});
    if (e_g >= 0) begin
      exp_b = (e_op >= 4'd5 && e_op <= 4'd7) ? {27'd0, e_b[4:0]} : e_b;
      chk("m_alu_bus", {24'd0, bus}, (e_op < 4'd8) ? (32'd1 << e_op) : 32'd0);
      chk("m_alu_operand_1", alu_operand_1, e_a);
      chk("m_alu_operand_2", alu_operand_2, exp_b);
    end else begin
      chk("m_quiet_bus", {24'd0, bus} | alu_operand_1 | alu_operand_2, 32'd0);
    end
    chk("m_resp0_valid", {31'd0, resp0_valid}, {31'd0, m_pend[0]});
    chk("m_resp1_valid", {31'd0, resp1_valid}, {31'd0, m_pend[1]});
    if (m_pend[0]) begin
      chk("m_resp0_result", resp0_result, m_res[0]);
      chk("m_resp0_error", {31'd0, resp0_error}, {31'd0, m_err[0]});
    end
    if (m_pend[1]) begin
      chk("m_resp1_result", resp1_result, m_res[1]);
      chk("m_resp1_error", {31'd0, resp1_error}, {31'd0, m_err[1]});
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_pend[0] = 1'b0;
      m_pend[1] = 1'b0;
      m_last    = 1;
    end else begin
      if (e_hs) m_pend[e_hs_port] = 1'b0;
      if (e_g >= 0) begin
        m_pend[e_g] = 1'b1;
        m_res[e_g]  = ref_op(e_op, e_a, e_b);
        m_err[e_g]  = (e_op >= 4'd8);
        m_last      = e_g;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int port, input logic v, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b);
    if (port == 0) begin
      req0_valid = v; req0_op = op; req0_operand_1 = a; req0_operand_2 = b;
    end else begin
      req1_valid = v; req1_op = op; req1_operand_1 = a; req1_operand_2 = b;
    end
  endtask

  initial begin
    rst = 1'b1;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    req(0, 1'b1, 4'd0, 32'd1, 32'd1);
    req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    cyc();
    rst = 1'b0;
    req0_valid = 1'b0;
    @(negedge clk);
    chk("rst_resp0_valid", {31'd0, resp0_valid}, 32'd0);
    chk("rst_resp1_valid", {31'd0, resp1_valid}, 32'd0);
    chk("rst_resp0_result", resp0_result, 32'd0);
    chk("rst_resp1_error", {31'd0, resp1_error}, 32'd0);
    cyc();

    // Contention: port 0 wins first after reset, port 1 follows with no bubble.
    req(0, 1'b1, 4'd1, 32'd10, 32'd3);
    req(1, 1'b1, 4'd4, 32'h0000_00F0, 32'h0000_000F);
    @(negedge clk);
    chk("cont_ready0", {30'd0, req1_ready, req0_ready}, 32'd1);
    cyc();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("cont_res0", resp0_result, 32'd7);
    chk("cont_ready1", {30'd0, req1_ready, req0_ready}, 32'd2);
    cyc();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("cont_res1", resp1_result, 32'h0000_00FF);
    chk("cont_valid0_drop", {31'd0, resp0_valid}, 32'd0);
    cyc();

    // Single op.
    req(0, 1'b1, 4'd0, 32'd5, 32'd7);
    @(negedge clk);
    chk("add_ready", {31'd0, req0_ready}, 32'd1);
    chk("add_sel", {24'd0, bus}, 32'd1);
    cyc();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("add_valid", {31'd0, resp0_valid}, 32'd1);
    chk("add_res", resp0_result, 32'd12);
    chk("add_err", {31'd0, resp0_error}, 32'd0);
    cyc();

    // Shift amount masking, then SRA back-to-back.
    req(1, 1'b1, 4'd5, 32'd1, 32'h0000_0021);
    @(negedge clk);
    chk("sll_operand_2", alu_operand_2, 32'd1);
    cyc();
    req(1, 1'b1, 4'd6, 32'h8000_0000, 32'd4);
    @(negedge clk);
    chk("sll_res", resp1_result, 32'd2);
    chk("sra_ready", {31'd0, req1_ready}, 32'd1);
    cyc();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("sra_res", resp1_result, 32'hF800_0000);
    cyc();

    // Backpressure on port 0 blocks port 1 until the consumer is ready.
    resp0_ready = 1'b0;
    req(0, 1'b1, 4'd2, 32'h0000_00FF, 32'h0000_000F);
    @(negedge clk);
    chk("bp_accept", {31'd0, req0_ready}, 32'd1);
    cyc();
    req0_valid = 1'b0;
    req(1, 1'b1, 4'd0, 32'd1, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_res", resp0_result, 32'h0000_000F);
      chk("bp_req1_blocked", {31'd0, req1_ready}, 32'd0);
      cyc();
    end
    resp0_ready = 1'b1;
    @(negedge clk);
    chk("bp_req1_accept", {31'd0, req1_ready}, 32'd1);
    cyc();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("bp_res1", resp1_result, 32'd2);
    chk("bp_valid0_drop", {31'd0, resp0_valid}, 32'd0);
    cyc();

    // Illegal op, then a legal op clears the error.
    req(0, 1'b1, 4'd9, 32'd3, 32'd4);
    @(negedge clk);
    chk("ill_bus", {24'd0, bus}, 32'd0);
    chk("ill_ready", {31'd0, req0_ready}, 32'd1);
    cyc();
    req(0, 1'b1, 4'd0, 32'd2, 32'd2);
    @(negedge clk);
    chk("ill_res", resp0_result, 32'd0);
    chk("ill_err", {31'd0, resp0_error}, 32'd1);
    cyc();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("ill_clear_err", {31'd0, resp0_error}, 32'd0);
    chk("ill_next_res", resp0_result, 32'd4);
    cyc();

    // Reset while port 1 holds a result.
    resp1_ready = 1'b0;
    req(1, 1'b1, 4'd3, 32'd1, 32'd2);
    cyc();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("rh_valid1", {31'd0, resp1_valid}, 32'd1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req(0, 1'b1, 4'd0, 32'd8, 32'd8);
    req(1, 1'b1, 4'd0, 32'd9, 32'd9);
    @(negedge clk);
    chk("rh_valid1_drop", {31'd0, resp1_valid}, 32'd0);
    chk("rh_grant0_first", {30'd0, req1_ready, req0_ready}, 32'd1);
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp1_ready = 1'b1;
    cyc();
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
